// File: rtl/sat_fifo_pkg.sv
// Shared definitions for the clause FIFO tree drain side.
package sat_fifo_pkg;

  // Default clause width used by the tree and its reader
  localparam int unsigned ClauseWidthDef = 36;

  // Overflow event counter width (saturating)
  localparam int unsigned OfCntWidth = 8;

  // Reader controller states
  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StOfAck = 2'd2,
    StFlush = 2'd3
  } rd_state_e;

endpackage

// File: rtl/clause_skid_fifo.sv
// Small circular skid buffer with a first-word-fall-through head.
module clause_skid_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 36
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear_i,
  input  logic                     push_i,
  input  logic [Width-1:0]         push_data_i,
  input  logic                     pop_i,
  output logic [Width-1:0]         head_o,
  output logic                     head_valid_o,
  output logic [$clog2(Depth):0]   occupancy_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam logic [PtrW:0] FullCount = (PtrW + 1)'(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wptr_q, rptr_q;
  logic [PtrW:0]    count_q;
  logic             do_pop;
  logic             full;

  assign head_valid_o = (count_q != '0);
  assign full         = (count_q == FullCount);
  assign do_pop       = pop_i & head_valid_o;
  assign occupancy_o  = count_q;
  // Head is forced to zero when empty so the downstream bus idles at 0
  assign head_o       = head_valid_o ? mem_q[rptr_q] : '0;

  // Storage array; contents need no reset since the head is gated by count
  always_ff @(posedge clk) begin
    if (push_i) begin
      mem_q[wptr_q] <= push_data_i;
    end
  end

  // Pointers and occupancy; clear discards everything including a same-cycle push
  always_ff @(posedge clk) begin
    if (reset || clear_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_i) wptr_q <= wptr_q + 1'b1;
      if (do_pop) rptr_q <= rptr_q + 1'b1;
      unique case ({push_i, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

`ifndef SYNTHESIS
  no_overflow: assert property (@(posedge clk) disable iff (reset || clear_i)
    !(push_i && !do_pop && full))
    else $error("clause_skid_fifo: push into full buffer");
`endif

endmodule

// File: rtl/clause_fifo_reader.sv
// Drain-side controller: pops the clause tree into a skid buffer, services overflow, flushes.
module clause_fifo_reader
  import sat_fifo_pkg::*;
#(
  parameter int unsigned CLAUSE_WIDTH = ClauseWidthDef,
  parameter int unsigned SKID_DEPTH   = 4,
  parameter int unsigned CNT_WIDTH    = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en_i,
  input  logic                    flush_i,
  input  logic                    fifo_empty_i,
  input  logic [CLAUSE_WIDTH-1:0] fifo_clause_i,
  input  logic                    fifo_of_i,
  output logic                    fifo_rden_o,
  output logic                    fifo_cof_o,
  output logic [CLAUSE_WIDTH-1:0] clause_o,
  output logic                    clause_valid_o,
  input  logic                    clause_ready_i,
  output logic                    flush_done_o,
  output logic                    of_sticky_o,
  input  logic                    clr_of_i,
  output logic [OfCntWidth-1:0]   of_count_o,
  output logic [CNT_WIDTH-1:0]    clause_count_o
);

  localparam int unsigned OccW = $clog2(SKID_DEPTH) + 1;

  rd_state_e             state_q, state_d;
  logic                  inflight_q;
  logic [OfCntWidth-1:0] of_count_q;
  logic                  of_sticky_q;
  logic [CNT_WIDTH-1:0]  clause_count_q;

  logic [OccW-1:0]       occ;
  logic [OccW:0]         credit_used;
  logic                  credit_ok;
  logic                  skid_push, skid_pop, skid_clear;

  // Occupancy plus the outstanding read must leave room for the returning word
  assign credit_used = {1'b0, occ} + {{OccW{1'b0}}, inflight_q};
  assign credit_ok   = credit_used < (OccW + 1)'(SKID_DEPTH);

  // Read data returning during FLUSH is dropped; clear on FLUSH entry beats any push/pop
  assign skid_push  = inflight_q & (state_q != StFlush);
  assign skid_pop   = clause_valid_o & clause_ready_i;
  assign skid_clear = (state_q != StFlush) & (state_d == StFlush);

  assign of_count_o     = of_count_q;
  assign of_sticky_o    = of_sticky_q;
  assign clause_count_o = clause_count_q;

  clause_skid_fifo #(
    .Depth (SKID_DEPTH),
    .Width (CLAUSE_WIDTH)
  ) u_skid (
    .clk          (clk),
    .reset        (reset),
    .clear_i      (skid_clear),
    .push_i       (skid_push),
    .push_data_i  (fifo_clause_i),
    .pop_i        (skid_pop),
    .head_o       (clause_o),
    .head_valid_o (clause_valid_o),
    .occupancy_o  (occ)
  );

  // Next-state and read/clear/done outputs
  always_comb begin
    state_d      = state_q;
    fifo_rden_o  = 1'b0;
    fifo_cof_o   = 1'b0;
    flush_done_o = 1'b0;
    case (state_q)
      StIdle: begin
        if (flush_i)   state_d = StFlush;
        else if (en_i) state_d = StRun;
      end
      StRun: begin
        fifo_rden_o = ~fifo_empty_i & credit_ok;
        if (flush_i)        state_d = StFlush;
        else if (fifo_of_i) state_d = StOfAck;
        else if (!en_i)     state_d = StIdle;
      end
      StOfAck: begin
        fifo_cof_o  = 1'b1;
        fifo_rden_o = ~fifo_empty_i & credit_ok;
        state_d     = StRun;
      end
      StFlush: begin
        fifo_rden_o = ~fifo_empty_i;
        if (fifo_empty_i && !inflight_q) begin
          flush_done_o = 1'b1;
          state_d      = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State, in-flight tracking and status counters
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= StIdle;
      inflight_q     <= 1'b0;
      of_count_q     <= '0;
      of_sticky_q    <= 1'b0;
      clause_count_q <= '0;
    end else begin
      state_q    <= state_d;
      inflight_q <= fifo_rden_o;
      if (skid_pop) clause_count_q <= clause_count_q + 1'b1;
      if (clr_of_i) begin
        of_count_q  <= '0;
        of_sticky_q <= 1'b0;
      end else if (state_q == StOfAck) begin
        of_sticky_q <= 1'b1;
        if (of_count_q != '1) of_count_q <= of_count_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_clause_fifo_reader.sv
// Directed bench for clause_fifo_reader: stream table plus hand-written corner sequences.
module tb_clause_fifo_reader;

  localparam int unsigned CW   = 36;
  localparam int unsigned SD   = 4;
  localparam int unsigned CNTW = 16;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            en_i = 1'b0;
  logic            flush_i = 1'b0;
  logic            fifo_empty_i;
  logic [CW-1:0]   fifo_clause_i = '0;
  logic            fifo_of_i = 1'b0;
  logic            fifo_rden_o;
  logic            fifo_cof_o;
  logic [CW-1:0]   clause_o;
  logic            clause_valid_o;
  logic            clause_ready_i = 1'b0;
  logic            flush_done_o;
  logic            of_sticky_o;
  logic            clr_of_i = 1'b0;
  logic [7:0]      of_count_o;
  logic [CNTW-1:0] clause_count_o;

  always #5 clk = ~clk;

  clause_fifo_reader #(
    .CLAUSE_WIDTH (CW),
    .SKID_DEPTH   (SD),
    .CNT_WIDTH    (CNTW)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .en_i           (en_i),
    .flush_i        (flush_i),
    .fifo_empty_i   (fifo_empty_i),
    .fifo_clause_i  (fifo_clause_i),
    .fifo_of_i      (fifo_of_i),
    .fifo_rden_o    (fifo_rden_o),
    .fifo_cof_o     (fifo_cof_o),
    .clause_o       (clause_o),
    .clause_valid_o (clause_valid_o),
    .clause_ready_i (clause_ready_i),
    .flush_done_o   (flush_done_o),
    .of_sticky_o    (of_sticky_o),
    .clr_of_i       (clr_of_i),
    .of_count_o     (of_count_o),
    .clause_count_o (clause_count_o)
  );

  // Tree model: main process appends at tree_wr, model pops at tree_rd, 1-cycle read latency
  logic [CW-1:0] tree_mem [256];
  logic [7:0]    tree_wr = '0;
  logic [7:0]    tree_rd = '0;
  assign fifo_empty_i = (tree_wr == tree_rd);

  always @(posedge clk) begin
    if (fifo_rden_o && !fifo_empty_i) begin
      fifo_clause_i <= tree_mem[tree_rd];
      tree_rd       <= tree_rd + 8'd1;
    end
  end

  // Monitor: records reads, handshakes and pulses with their cycle numbers
  int            cyc = 0;
  int            cof_total = 0;
  int            done_total = 0;
  int            rd_total = 0;
  int            rd_cyc[$];
  int            hs_cyc[$];
  logic [CW-1:0] hs_data[$];

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (!reset) begin
      if (fifo_rden_o) begin
        rd_total = rd_total + 1;
        rd_cyc.push_back(cyc);
      end
      if (clause_valid_o && clause_ready_i) begin
        hs_data.push_back(clause_o);
        hs_cyc.push_back(cyc);
      end
      if (fifo_cof_o)   cof_total  = cof_total + 1;
      if (flush_done_o) done_total = done_total + 1;
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic load(input logic [CW-1:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      tree_mem[tree_wr] = base + CW'(i);
      tree_wr = tree_wr + 8'd1;
    end
  endtask

  task automatic wait_hs(input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (hs_data.size() >= target) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (hs_data.size() >= target) ok = 1'b1;
  endtask

  // Count out-of-order deliveries starting at queue index idx
  function automatic int seq_errors(input int idx, input logic [CW-1:0] base, input int n);
    int bad;
    bad = 0;
    for (int i = 0; i < n; i++) begin
      if (idx + i >= hs_data.size()) bad++;
      else if (hs_data[idx + i] !== base + CW'(i)) bad++;
    end
    return bad;
  endfunction

  typedef struct {
    int            n;
    logic [CW-1:0] base;
    int            stall_at;
    int            stall_len;
    int            exp_delivered;
    int            max_stall_reads;
  } stream_vec_t;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    stream_vec_t     vecs[4];
    int              hs0, rd0, cof0, done0, rdt0;
    logic [CNTW-1:0] cc0;
    int              stall_reads, unstable, delivered;
    logic            ref_v;
    logic [CW-1:0]   ref_d;
    bit              ok, stall, seen, found;

    vecs[0] = '{n: 20, base: 36'h100, stall_at: 5, stall_len: 6, exp_delivered: 20, max_stall_reads: 4};
    vecs[1] = '{n: 8,  base: 36'h200, stall_at: 0, stall_len: 10, exp_delivered: 8, max_stall_reads: 4};
    vecs[2] = '{n: 5,  base: 36'h300, stall_at: 0, stall_len: 0, exp_delivered: 5, max_stall_reads: 0};
    vecs[3] = '{n: 12, base: 36'hA_BCDE_0000, stall_at: 2, stall_len: 3, exp_delivered: 12,
                max_stall_reads: 4};

    // Reset values
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_ctrl", {fifo_rden_o, fifo_cof_o, clause_valid_o, flush_done_o, of_sticky_o}, 0);
    check("reset_clause", clause_o, 0);
    check("reset_counts", {of_count_o, clause_count_o}, 0);
    reset = 1'b0;
    @(negedge clk);

    // Streaming latency and throughput
    load(36'h1, 10);
    rd0 = rd_cyc.size();
    hs0 = hs_data.size();
    en_i = 1'b1;
    clause_ready_i = 1'b1;
    wait_hs(hs0 + 10, 60, ok);
    check("stream_complete", ok, 1);
    if (ok) begin
      check("stream_first_latency", hs_cyc[hs0] - rd_cyc[rd0], 2);
      check("stream_back_to_back", hs_cyc[hs0 + 9] - hs_cyc[hs0], 9);
      check("stream_order", seq_errors(hs0, 36'h1, 10), 0);
    end
    check("stream_count", clause_count_o, 10);

    // Table-driven streams with backpressure windows
    for (int v = 0; v < 4; v++) begin
      stall_reads = 0;
      unstable    = 0;
      ref_v       = 1'b0;
      ref_d       = '0;
      hs0 = hs_data.size();
      cc0 = clause_count_o;
      load(vecs[v].base, vecs[v].n);
      for (int c = 0; c < 400 && (hs_data.size() - hs0) < vecs[v].n; c++) begin
        stall = (c >= vecs[v].stall_at) && (c < vecs[v].stall_at + vecs[v].stall_len);
        clause_ready_i = !stall;
        #1;
        if (stall) begin
          if (fifo_rden_o) stall_reads++;
          if (c == vecs[v].stall_at) begin
            ref_v = clause_valid_o;
            ref_d = clause_o;
          end else if (ref_v && (clause_valid_o !== 1'b1 || clause_o !== ref_d)) begin
            unstable++;
          end
        end
        @(negedge clk);
      end
      clause_ready_i = 1'b1;
      delivered = hs_data.size() - hs0;
      check($sformatf("vec%0d_delivered", v), delivered, vecs[v].exp_delivered);
      check($sformatf("vec%0d_order", v), seq_errors(hs0, vecs[v].base, vecs[v].n), 0);
      check($sformatf("vec%0d_count_delta", v), clause_count_o - cc0,
            CNTW'(vecs[v].exp_delivered));
      check($sformatf("vec%0d_stall_reads_le_max", v), stall_reads <= vecs[v].max_stall_reads, 1);
      check($sformatf("vec%0d_stable_while_stalled", v), unstable, 0);
    end

    // Overflow handling
    cof0 = cof_total;
    fifo_of_i = 1'b1;
    #1;
    check("of_no_early_cof", fifo_cof_o, 0);
    @(negedge clk);
    check("of_cof_pulse", fifo_cof_o, 1);
    fifo_of_i = 1'b0;
    @(negedge clk);
    check("of_cof_drop", fifo_cof_o, 0);
    check("of_count_1", of_count_o, 1);
    check("of_sticky_set", of_sticky_o, 1);
    check("of_single_pulse", cof_total - cof0, 1);
    for (int k = 0; k < 3; k++) begin
      fifo_of_i = 1'b1;
      @(negedge clk);
      fifo_of_i = 1'b0;
      @(negedge clk);
    end
    check("of_count_4", of_count_o, 4);
    check("of_pulses_4", cof_total - cof0, 4);
    for (int k = 0; k < 252; k++) begin
      fifo_of_i = 1'b1;
      @(negedge clk);
      fifo_of_i = 1'b0;
      @(negedge clk);
    end
    check("of_count_saturated", of_count_o, 255);
    clr_of_i = 1'b1;
    @(negedge clk);
    clr_of_i = 1'b0;
    check("of_clear", {of_sticky_o, of_count_o}, 0);
    // Clear in the same cycle as an OF_ACK increment
    fifo_of_i = 1'b1;
    @(negedge clk);
    check("of_ack_for_clr", fifo_cof_o, 1);
    clr_of_i = 1'b1;
    fifo_of_i = 1'b0;
    @(negedge clk);
    clr_of_i = 1'b0;
    check("of_clear_wins", {of_sticky_o, of_count_o}, 0);

    // Simultaneous flush and overflow in RUN
    cof0  = cof_total;
    done0 = done_total;
    flush_i = 1'b1;
    fifo_of_i = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (flush_done_o) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    flush_i = 1'b0;
    fifo_of_i = 1'b0;
    @(negedge clk);
    check("fof_done_seen", found, 1);
    check("fof_no_cof", cof_total - cof0, 0);
    check("fof_done_once", done_total - done0, 1);
    check("fof_of_count", {of_sticky_o, of_count_o}, 0);

    // Flush with 2 clauses in skid and 7 in the tree
    clause_ready_i = 1'b0;
    load(36'h700, 2);
    repeat (6) @(negedge clk);
    check("flush_pre_valid", clause_valid_o, 1);
    en_i = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_retains_skid", {clause_valid_o, clause_o}, {1'b1, 36'h700});
    load(36'h800, 7);
    rdt0  = rd_total;
    done0 = done_total;
    cc0   = clause_count_o;
    flush_i = 1'b1;
    @(negedge clk);
    check("flush_valid_drop", clause_valid_o, 0);
    found = 1'b0;
    for (int c = 0; c < 30; c++) begin
      #1;
      if (flush_done_o) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    flush_i = 1'b0;
    @(negedge clk);
    check("flush_done_seen", found, 1);
    check("flush_reads", rd_total - rdt0, 7);
    check("flush_done_once", done_total - done0, 1);
    check("flush_count_kept", clause_count_o, cc0);
    check("flush_idle_quiet", {fifo_rden_o, clause_valid_o, flush_done_o}, 0);

    // Reset with 3 clauses buffered and 1 read in flight
    en_i = 1'b1;
    @(negedge clk);
    fifo_of_i = 1'b1;
    @(negedge clk);
    fifo_of_i = 1'b0;
    @(negedge clk);
    check("rst_pre_of_count", of_count_o, 1);
    load(36'h500, 10);
    seen  = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (fifo_rden_o) seen = 1'b1;
      else if (seen) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("rst_setup_reached", found, 1);
    reset = 1'b1;
    @(negedge clk);
    check("rst_ctrl", {fifo_rden_o, fifo_cof_o, clause_valid_o, flush_done_o, of_sticky_o}, 0);
    check("rst_clause", clause_o, 0);
    check("rst_counts", {of_count_o, clause_count_o}, 0);
    reset = 1'b0;
    clause_ready_i = 1'b1;
    rd0 = rd_cyc.size();
    hs0 = hs_data.size();
    wait_hs(hs0 + 6, 60, ok);
    check("rst_resume_complete", ok, 1);
    if (ok) begin
      check("rst_first_from_new_read", hs_data[hs0], 36'h504);
      check("rst_first_latency_ge2", (hs_cyc[hs0] - rd_cyc[rd0]) >= 2, 1);
      check("rst_resume_order", seq_errors(hs0, 36'h504, 6), 0);
    end
    check("rst_resume_count", clause_count_o, 6);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
